// File: rtl/calc_cmd_sequencer.sv
// Queues (number, opcode) commands and plays each one into the 8-bit calculator
// with a setup / Enter-press / release sequence, capturing NumOut once per command.
module calc_cmd_sequencer #(
    parameter int DEPTH        = 4,
    parameter int ENTER_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_num,
    input  logic [1:0] cmd_op,
    output logic [7:0] NumIn,
    output logic [1:0] OpIn,
    output logic       Enter,
    input  logic [7:0] NumOut,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       busy,
    output logic [7:0] done_count
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (ENTER_CYCLES > GAP_CYCLES) ? ENTER_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [AW:0]   PTR_INC    = (AW + 1)'(1'b1);
    localparam logic [CW-1:0] CNT_DEC    = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
    localparam logic [CW-1:0] ENTER_LOAD = CW'(ENTER_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [9:0]    mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic [9:0]    head_s;
    logic          empty_s, full_s, push_s, pop_s;
    logic [7:0]    num_r, num_s;
    logic [1:0]    op_r, op_s;
    logic          enter_r, enter_s;
    logic          res_valid_r, res_valid_s;
    logic [7:0]    res_data_r, res_data_s;
    logic [7:0]    done_r, done_s;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign cmd_ready = rst_n & ena & ~full_s;
    assign push_s    = cmd_valid & cmd_ready;
    assign head_s    = mem_r[rd_ptr_r[AW-1:0]];

    assign NumIn      = num_r;
    assign OpIn       = op_r;
    assign Enter      = enter_r;
    assign res_data   = res_data_r;
    assign res_valid  = res_valid_r & ena;
    assign done_count = done_r;
    assign busy       = (state_r != ST_IDLE) | ~empty_s;

    // Command FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {cmd_op, cmd_num};
                wr_ptr_r                <= wr_ptr_r + PTR_INC;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
        end
    end

    // Sequencer state and registered calculator-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            num_r       <= 8'd0;
            op_r        <= 2'd0;
            enter_r     <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= 8'd0;
            done_r      <= 8'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            num_r       <= num_s;
            op_r        <= op_s;
            enter_r     <= enter_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            done_r      <= done_s;
        end
    end

    // Next-state logic; with ena low everything holds, including a pending result pulse.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        num_s       = num_r;
        op_s        = op_r;
        enter_s     = enter_r;
        res_valid_s = res_valid_r;
        res_data_s  = res_data_r;
        done_s      = done_r;
        pop_s       = 1'b0;
        if (ena) begin
            res_valid_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    enter_s = 1'b0;
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        num_s   = head_s[7:0];
                        op_s    = head_s[9:8];
                        state_s = ST_PRESENT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRESENT: begin
                    enter_s = 1'b1;
                    cnt_s   = ENTER_LOAD;
                    state_s = ST_ASSERT;
                end
                ST_ASSERT: begin
                    if (cnt_r == CNT_ZERO) begin
                        enter_s     = 1'b0;
                        res_data_s  = NumOut;
                        res_valid_s = 1'b1;
                        done_s      = done_r + 8'd1;
                        cnt_s       = GAP_LOAD;
                        state_s     = ST_RELEASE;
                    end else begin
                        cnt_s = cnt_r - CNT_DEC;
                    end
                end
                ST_RELEASE: begin
                    enter_s = 1'b0;
                    if (cnt_r != CNT_ZERO) begin
                        cnt_s = cnt_r - CNT_DEC;
                    end else if (!empty_s) begin
                        pop_s   = 1'b1;
                        num_s   = head_s[7:0];
                        op_s    = head_s[9:8];
                        state_s = ST_PRESENT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    enter_s = 1'b0;
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: a behavioural calculator drives NumOut and a
// command-queue scoreboard predicts every result, plus directed literal checks.
module tb_calc_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int EC    = 2;
    localparam int GC    = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_num = 8'd0;
    logic [1:0] cmd_op = 2'd0;
    logic       cmd_ready;
    logic [7:0] NumIn;
    logic [1:0] OpIn;
    logic       Enter;
    logic [7:0] NumOut;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic [7:0] done_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_push_cyc = 0;

    calc_cmd_sequencer #(.DEPTH(DEPTH), .ENTER_CYCLES(EC), .GAP_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num(cmd_num), .cmd_op(cmd_op),
        .NumIn(NumIn), .OpIn(OpIn), .Enter(Enter), .NumOut(NumOut),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] calc(input logic [7:0] acc, input logic [7:0] num,
                                        input logic [1:0] op);
        case (op)
            2'd0:    return acc + num;
            2'd1:    return num - acc;
            2'd2:    return acc | num;
            default: return (acc == num) ? 8'd1 : 8'd0;
        endcase
    endfunction

    // Calculator: executes once on the first edge that sees Enter high.
    logic [7:0] calc_acc;
    logic       calc_prev;
    int         commits;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_acc  <= 8'd0;
            calc_prev <= 1'b0;
            commits   <= 0;
        end else begin
            calc_prev <= Enter;
            if (Enter && !calc_prev) begin
                calc_acc <= calc(calc_acc, NumIn, OpIn);
                commits  <= commits + 1;
            end
        end
    end
    assign NumOut = calc_acc;

    // Scoreboard: accepted commands in order, applied to a model accumulator.
    logic [9:0] cmd_q [$];
    logic [7:0] res_log [$];
    int         res_t [$];
    logic [7:0] m_acc = 8'd0;
    int         m_count = 0;
    logic [9:0] sb_c;
    always @(negedge clk) begin
        if (!rst_n) begin
            cmd_q.delete();
            m_acc   = 8'd0;
            m_count = 0;
        end else begin
            if (res_valid) begin
                res_log.push_back(res_data);
                res_t.push_back(cyc);
                if (cmd_q.size() == 0) begin
                    chk("res_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_c    = cmd_q.pop_front();
                    m_acc   = calc(m_acc, sb_c[7:0], sb_c[9:8]);
                    m_count = m_count + 1;
                    chk("res_data", res_data, m_acc);
                    chk("done_count", done_count, m_count % 256);
                end
            end
            if (cmd_valid && cmd_ready) cmd_q.push_back({cmd_op, cmd_num});
        end
    end

    // Enter protocol: high exactly EC cycles when not frozen, low at least GC+1 between presses.
    int hi_len = 0, lo_len = 100;
    bit dirty = 1'b0, prev_e = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_len = 0; lo_len = 100; dirty = 1'b0; prev_e = 1'b0;
        end else begin
            if (Enter) begin
                if (!prev_e) begin
                    chk("enter_gap_ok", (lo_len >= GC + 1), 32'd1);
                    hi_len = 0;
                    dirty  = 1'b0;
                end
                hi_len++;
                if (!ena) dirty = 1'b1;
            end else begin
                if (prev_e && !dirty) chk("enter_high_len", hi_len, EC);
                if (prev_e) lo_len = 0;
                lo_len++;
            end
            prev_e = Enter;
        end
    end

    function automatic logic [31:0] log_at(input int i);
        if (i < res_log.size()) return {24'd0, res_log[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic push(input logic [7:0] n, input logic [1:0] op);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_num = n; cmd_op = op;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk); ok = cmd_ready;
            @(posedge clk); #1;
        end
        if (ok) last_push_cyc = cyc;
        else chk("push_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk); k++;
        end
        chk("idle_timeout", busy, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_push;
        int c0, dc0, seen;
        logic [7:0] rdy;
        int idx;
        ena = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_enter", Enter, 0);
        chk("rst_numin", NumIn, 0);
        chk("rst_opin", OpIn, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_count, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", cmd_ready, 1);

        // (5,add),(3,add) back-to-back
        res_log.delete(); res_t.delete();
        push(8'd5, 2'd0); first_push = last_push_cyc;
        push(8'd3, 2'd0);
        wait_idle(100);
        chk("seq1_count", res_log.size(), 2);
        chk("seq1_r0", log_at(0), 5);
        chk("seq1_r1", log_at(1), 8);
        if (res_t.size() >= 2) begin
            chk("seq1_latency", res_t[0] - first_push, 4);
            chk("seq1_spacing", res_t[1] - res_t[0], 1 + EC + GC);
        end else begin
            chk("seq1_times", res_t.size(), 2);
        end
        chk("seq1_done", done_count, 2);

        // (10,sub),(2,eq)
        res_log.delete();
        push(8'd10, 2'd1);
        push(8'd2, 2'd3);
        wait_idle(100);
        chk("seq2_r0", log_at(0), 2);
        chk("seq2_r1", log_at(1), 1);
        chk("seq2_drained", cmd_q.size(), 0);

        // hold cmd_valid through a full FIFO
        res_log.delete();
        idx = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_num = 8'h11 * (idx + 1); cmd_op = 2'(idx);
            @(negedge clk); rdy[i] = cmd_ready;
            @(posedge clk); #1;
            if (rdy[i]) idx++;
        end
        cmd_valid = 1'b0;
        chk("full_ready_pattern", rdy, 8'h5F);
        wait_idle(200);
        chk("full_results", res_log.size(), 6);
        chk("full_drained", cmd_q.size(), 0);

        // freeze mid-ASSERT
        c0 = commits; dc0 = done_count;
        push(8'h0F, 2'd2);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); seen = Enter;
        end
        chk("frz_enter_seen", seen, 1);
        @(posedge clk); #1 ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_enter_held", Enter, 1);
            chk("frz_no_res", res_valid, 0);
            chk("frz_no_ready", cmd_ready, 0);
            @(posedge clk); #1;
        end
        ena = 1'b1;
        wait_idle(100);
        chk("frz_commits", commits - c0, 1);
        chk("frz_done", done_count, (dc0 + 1) % 256);
        chk("frz_drained", cmd_q.size(), 0);

        // async reset mid-ASSERT with commands queued
        push(8'd7, 2'd0); push(8'd9, 2'd0); push(8'd4, 2'd0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk); seen = Enter;
        end
        chk("rstm_enter_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_enter", Enter, 0);
        chk("rstm_res_valid", res_valid, 0);
        chk("rstm_done", done_count, 0);
        chk("rstm_busy", busy, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); if (Enter || res_valid) seen++;
        end
        @(posedge clk); #1;
        chk("rstm_no_issue", seen, 0);
        chk("rstm_done_after", done_count, 0);

        // 256 zero adds wrap done_count
        res_log.delete();
        for (int i = 0; i < 256; i++) push(8'd0, 2'd0);
        wait_idle(200);
        chk("wrap_done", done_count, 0);
        chk("wrap_count", res_log.size(), 256);
        seen = 0;
        foreach (res_log[i]) if (res_log[i] != 8'd0) seen++;
        chk("wrap_all_zero", seen, 0);

        // randomized traffic with occasional freezes
        for (int i = 0; i < 600; i++) begin
            ena       = ($urandom_range(0, 7) != 0);
            cmd_valid = $urandom_range(0, 1);
            cmd_num   = 8'($urandom);
            cmd_op    = 2'($urandom);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; ena = 1'b1;
        wait_idle(200);
        chk("rand_drained", cmd_q.size(), 0);
        chk("rand_done", done_count, m_count % 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
